rob_multi_cdb: RTL and testbench
================================

# rob_multi_cdb

Parametrised reorder buffer for the Tomasulo out-of-order core: allocates tagged entries in program order from the dispatch stage and captures results from several CDB ports at once. It exposes busy/value state for operand lookup by the reservation stations and commits in order to the register file and store path. On a committed branch mispredict it flushes the whole buffer. It generalises the fixed 6-entry, single-result ROB to configurable depth, tag width and CDB port count, and adds commit back-pressure and mispredict flush.

## Interface
- DEPTH, 6, number of entries; must satisfy DEPTH <= 2**TAG_W - 1
- TAG_W, 4, tag width; tag 0 means "no entry"
- CDB_PORTS, 3, number of simultaneous CDB broadcast ports (ALU, CMP, LDST)
- clk  in  1  clock; the only clock
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_op_type  in  2  op_type_t (REG/ST/BR)
- alloc_rd  in  5  destination register (ignored for ST/BR)
- alloc_ready  out  1  an entry is free and no flush is in progress
- alloc_tag  out  TAG_W  tag that the next allocation receives; 0 when alloc_ready=0
- cdb_valid  in  CDB_PORTS  per-port result valid
- cdb_tag  in  CDB_PORTS*TAG_W  per-port ROB tag
- cdb_val  in  CDB_PORTS*32  per-port result (BR: the correct next PC)
- cdb_mispredict  in  CDB_PORTS  per-port branch-mispredict flag
- rob_busy  out  DEPTH  bit i-1 is high when tag i is allocated and its result is pending
- rob_vals  out  DEPTH*32  captured value per entry, indexed by tag-1
- commit_valid  out  1  head entry is allocated and complete
- commit_ready  in  1  consumer accepts the commit (store port may stall)
- commit_tag, commit_op_type, commit_rd, commit_val  out  TAG_W/2/5/32  head entry fields
- flush  out  1  one-cycle pulse after a mispredicted branch commits
- flush_pc  out  32  redirect target, valid while flush=1
- count  out  $clog2(DEPTH+1)  number of allocated entries

## Operation
- Circular buffer of entries {valid, busy, op_type, rd, val, mispredict}, with a head pointer, a tail pointer and a count. Tag = index+1.
- Allocate when alloc_valid && alloc_ready. At the edge: entry[tail] gets valid=1, busy=1, val=0, mispredict=0. Tail wraps DEPTH-1 -> 0.
- CDB write: for each port with cdb_valid, tag in 1..DEPTH and entry valid && busy: set busy=0, store val and mispredict. Writes are ignored for tag 0, tag > DEPTH, free entries or already-complete entries. If two ports carry the same tag in one cycle, the highest port index wins.
- Commit: commit_valid = entry[head].valid && !entry[head].busy. A commit occurs at the edge when commit_valid && commit_ready: the entry is freed and head advances with wrap. commit_rd is forced to 0 for ST/BR.
- Mispredict commit: a committed BR with mispredict=1 clears all valid bits, resets head, tail and count to 0, and registers flush=1 and flush_pc=val for exactly the next cycle.
- alloc_ready = (count < DEPTH) && !flush. It uses registered count only, so a same-cycle commit does not free a slot for a same-cycle allocation.
- An allocation at the same edge as a mispredict commit is discarded. A CDB write at that edge is discarded.
- Simultaneous allocation and normal commit: count is unchanged and both pointers advance.
- Empty: commit_valid=0. Full: alloc_ready=0 and alloc_tag=0.

## Timing
- Reset (rst=1 at an edge): all entries invalid, head=tail=count=0, flush=0, flush_pc=0. Outputs after reset: alloc_ready=1, alloc_tag=1, commit_valid=0, rob_busy=0, rob_vals=0, and all commit_* fields are 0. Reset has priority over every other event, including mid-flush.
- alloc_tag, alloc_ready, commit_* and rob_* are combinational from registered state (except under the macro below).
- Allocation is visible in rob_busy the cycle after the allocating edge.
- CDB result to commit_valid: 1 cycle (registered).
- Mispredict commit edge -> flush high for 1 cycle -> alloc_ready returns to 1 on the following cycle with alloc_tag=1.

## Configuration
- ROB_CDB_BYPASS_EN defined: rob_busy and rob_vals combinationally reflect this cycle's valid CDB writes, so a reservation station reading tag T sees busy=0 and the CDB value in the same cycle as the broadcast. commit_valid stays registered.
- ROB_CDB_BYPASS_EN not defined: rob_busy and rob_vals reflect only registered state, and results become visible one cycle after the broadcast.

## Structure
- In the shared ooo_types package:
  - ROB_DEPTH and the CDB port count constant
  - tag_t and op_type_t
  - a new rob_entry_t struct {valid, busy, op_type, rd, val, mispredict}
- The existing rob_out_t is superseded by the flattened rob_busy/rob_vals ports.
- One sub-module is natural: rob_cdb_match. It is per-entry and instantiated DEPTH times. It takes the entry tag and all CDB ports and returns hit, val and mispredict with highest-port priority.

## Test plan
- Reset, then 6 allocs (REG, rd=1..6) -> alloc_tag sequence 1..6, count=6, alloc_ready=0, alloc_tag=0.
- CDB writes tag 3 (0x33) and tag 1 (0x11) in one cycle on ports 0/2 -> next cycle commit_valid=1, commit_tag=1, commit_val=0x11. Tag 2 stays busy, so the head stalls after one commit.
- commit_ready=0 with a complete head for 3 cycles -> head held, commit_* stable. Then commit_ready=1 -> commit on that edge, count decrements.
- Fill, commit 2, allocate 2 -> tail wraps, new tags 1 and 2 are allocated, busy bits 0 and 1 are set.
- BR at tag 2 completes with mispredict=1, val=0x8000_0040, plus an alloc at the commit edge -> flush=1 and flush_pc=0x8000_0040 for one cycle, count=0, the alloc is dropped, alloc_tag=1 afterwards.
- With ROB_CDB_BYPASS_EN: CDB tag 4 = 0xABCD -> rob_busy[3]=0 and rob_vals[4th entry]=0xABCD in the same cycle. Without it, both appear one cycle later.

Source files
------------

// File: rtl/rob_multi_cdb_pkg.sv
// Shared types for the reorder buffer slice of the Tomasulo core.
//   ROB_DEPTH / ROB_TAG_W / ROB_CDB_PORTS : default geometry
//   tag_t       : ROB tag, 0 means "no entry"
//   op_type_t   : REG / ST / BR
//   rob_entry_t : one reorder-buffer slot
package rob_multi_cdb_pkg;

  localparam int unsigned ROB_DEPTH     = 6;
  localparam int unsigned ROB_TAG_W     = 4;
  localparam int unsigned ROB_CDB_PORTS = 3;

  typedef logic [ROB_TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    OP_REG = 2'd0,
    OP_ST  = 2'd1,
    OP_BR  = 2'd2
  } op_type_t;

  typedef struct packed {
    logic        valid;
    logic        busy;
    op_type_t    op_type;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mispredict;
  } rob_entry_t;

endpackage

// File: rtl/rob_cdb_match.sv
// Per-entry CDB matcher: compares one ROB tag against every CDB port.
//   entry_tag      : tag of this entry (index+1, never 0)
//   cdb_valid/tag/val/mispredict : flattened CDB ports
//   hit/val/mispredict : result of the highest-index matching port
module rob_cdb_match #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CDB_PORTS = 3
) (
  input  logic [TAG_W-1:0]           entry_tag,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]    cdb_val,
  input  logic [CDB_PORTS-1:0]       cdb_mispredict,
  output logic                       hit,
  output logic [31:0]                val,
  output logic                       mispredict
);

  // Ascending scan: a later (higher) port overrides an earlier match.
  always_comb begin
    hit        = 1'b0;
    val        = '0;
    mispredict = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == entry_tag)) begin
        hit        = 1'b1;
        val        = cdb_val[p*32 +: 32];
        mispredict = cdb_mispredict[p];
      end
    end
  end

endmodule

// File: rtl/rob_multi_cdb.sv
// Reorder buffer with multiple CDB write ports, in-order commit with
// back-pressure and whole-buffer flush on a committed branch mispredict.
//   alloc_*   : dispatch-side allocation (tag = index+1, 0 = none)
//   cdb_*     : CDB_PORTS flattened result broadcasts
//   rob_busy/rob_vals : operand lookup state, indexed by tag-1
//   commit_*  : head entry, consumed when commit_valid && commit_ready
//   flush/flush_pc : one-cycle redirect after a mispredicted BR commits
//   count     : allocated entries
// Optional macro ROB_CDB_BYPASS_EN: rob_busy/rob_vals forward this cycle's
// CDB writes combinationally.
module rob_multi_cdb
  import rob_multi_cdb_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned TAG_W     = ROB_TAG_W,
  parameter int unsigned CDB_PORTS = ROB_CDB_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [1:0]                   alloc_op_type,
  input  logic [4:0]                   alloc_rd,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [CDB_PORTS-1:0]         cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_PORTS*32-1:0]      cdb_val,
  input  logic [CDB_PORTS-1:0]         cdb_mispredict,
  output logic [DEPTH-1:0]             rob_busy,
  output logic [DEPTH*32-1:0]          rob_vals,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output logic [TAG_W-1:0]             commit_tag,
  output logic [1:0]                   commit_op_type,
  output logic [4:0]                   commit_rd,
  output logic [31:0]                  commit_val,
  output logic                         flush,
  output logic [31:0]                  flush_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH > (2**TAG_W) - 1) begin : g_bad_cfg
    $error("rob_multi_cdb: DEPTH must not exceed 2**TAG_W-1");
  end

  rob_entry_t       ent [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic [DEPTH-1:0] m_hit, m_mis, wr_en;
  logic [31:0]      m_val [DEPTH];
  rob_entry_t       head_ent;
  logic             do_commit, do_alloc, do_mis;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    rob_cdb_match #(
      .TAG_W     (TAG_W),
      .CDB_PORTS (CDB_PORTS)
    ) u_match (
      .entry_tag      (TAG_W'(i+1)),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_val        (cdb_val),
      .cdb_mispredict (cdb_mispredict),
      .hit            (m_hit[i]),
      .val            (m_val[i]),
      .mispredict     (m_mis[i])
    );
  end

  always_comb begin
    head_ent       = ent[head];
    alloc_ready    = (cnt_q < FULL) && !flush_q;
    alloc_tag      = alloc_ready ? TAG_W'(tail) + TAG_W'(1) : '0;
    commit_valid   = head_ent.valid && !head_ent.busy;
    commit_tag     = commit_valid ? TAG_W'(head) + TAG_W'(1) : '0;
    commit_op_type = commit_valid ? head_ent.op_type : '0;
    commit_rd      = (commit_valid && head_ent.op_type == OP_REG) ? head_ent.rd : '0;
    commit_val     = commit_valid ? head_ent.val : '0;
    do_commit      = commit_valid && commit_ready;
    do_mis         = do_commit && (head_ent.op_type == OP_BR) && head_ent.mispredict;
    do_alloc       = alloc_valid && alloc_ready;

    wr_en    = '0;
    rob_busy = '0;
    rob_vals = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Only pending entries accept a result; free or completed ones ignore it.
      wr_en[i]             = m_hit[i] && ent[i].valid && ent[i].busy;
      rob_busy[i]          = ent[i].valid && ent[i].busy;
      rob_vals[i*32 +: 32] = ent[i].val;
`ifdef ROB_CDB_BYPASS_EN
      if (wr_en[i]) begin
        rob_busy[i]          = 1'b0;
        rob_vals[i*32 +: 32] = m_val[i];
      end
`endif
    end
  end

  assign count    = cnt_q;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      head       <= '0;
      tail       <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (do_mis) begin
      // Mispredict commit wins over any same-edge allocation or CDB write.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].busy  <= 1'b0;
      end
      head       <= '0;
      tail       <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b1;
      flush_pc_q <= head_ent.val;
    end else begin
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      // CDB (busy entries), commit (complete head) and allocate (free tail)
      // always target distinct entries, so their order here is irrelevant.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          ent[i].busy       <= 1'b0;
          ent[i].val        <= m_val[i];
          ent[i].mispredict <= m_mis[i];
        end
      end
      if (do_commit) begin
        ent[head].valid <= 1'b0;
        head            <= (head == LAST) ? '0 : head + PTR_W'(1);
      end
      if (do_alloc) begin
        ent[tail] <= '{valid: 1'b1, busy: 1'b1, op_type: op_type_t'(alloc_op_type),
                       rd: alloc_rd, val: '0, mispredict: 1'b0};
        tail      <= (tail == LAST) ? '0 : tail + PTR_W'(1);
      end
      case ({do_alloc, do_commit})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed, table-driven bench for rob_multi_cdb (DEPTH=6, TAG_W=4, 3 ports).
module tb_rob_multi_cdb;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [1:0]  alloc_op_type;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_val;
  logic [2:0]  cdb_mispredict;
  logic [5:0]  rob_busy;
  logic [191:0] rob_vals;
  logic        commit_valid;
  logic        commit_ready;
  logic [3:0]  commit_tag;
  logic [1:0]  commit_op_type;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_multi_cdb #(.DEPTH(6), .TAG_W(4), .CDB_PORTS(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_op_type(alloc_op_type), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict),
    .rob_busy(rob_busy), .rob_vals(rob_vals),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_op_type(commit_op_type),
    .commit_rd(commit_rd), .commit_val(commit_val),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  typedef struct {
    logic        av;  logic [1:0] op;  logic [4:0] rd;
    logic [2:0]  cv;  logic [11:0] ct; logic [95:0] cval; logic [2:0] cm;
    logic        cr;
    logic        ar;  logic [3:0] at;
    logic        cvld; logic [3:0] ctag; logic [1:0] cop; logic [4:0] crd; logic [31:0] cvl;
    logic [2:0]  cnt; logic fl; logic [31:0] fpc; logic [5:0] busy;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(
    input logic av, input logic [1:0] op, input logic [4:0] rd,
    input logic [2:0] cv, input logic [11:0] ct, input logic [95:0] cval,
    input logic [2:0] cm, input logic cr,
    input logic ar, input logic [3:0] at,
    input logic cvld, input logic [3:0] ctag, input logic [1:0] cop,
    input logic [4:0] crd, input logic [31:0] cvl,
    input logic [2:0] cnt, input logic fl, input logic [31:0] fpc, input logic [5:0] busy);
    vec_t v;
    v.av = av; v.op = op; v.rd = rd; v.cv = cv; v.ct = ct; v.cval = cval; v.cm = cm;
    v.cr = cr; v.ar = ar; v.at = at; v.cvld = cvld; v.ctag = ctag; v.cop = cop;
    v.crd = crd; v.cvl = cvl; v.cnt = cnt; v.fl = fl; v.fpc = fpc; v.busy = busy;
    return v;
  endfunction

  function automatic logic [95:0] v3(input logic [31:0] p2, input logic [31:0] p1,
                                     input logic [31:0] p0);
    return {p2, p1, p0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_op_type = 2'd0; alloc_rd = 5'd0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; cdb_mispredict = '0;
    commit_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_byp_val;
    logic        exp_byp_busy;

    //        av op rd  cv      ct                    cval                                  cm      cr  ar at cvld ctag cop crd cvl            cnt fl fpc            busy
    vecs[0]  = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          6'b000000);
    vecs[1]  = mk(1, 0, 1,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          6'b000000);
    vecs[2]  = mk(1, 0, 2,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 2, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,          6'b000001);
    vecs[3]  = mk(1, 0, 3,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 3, 0, 0, 0, 0, 32'h0,          2, 0, 32'h0,          6'b000011);
    vecs[4]  = mk(1, 0, 4,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 4, 0, 0, 0, 0, 32'h0,          3, 0, 32'h0,          6'b000111);
    vecs[5]  = mk(1, 0, 5,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 5, 0, 0, 0, 0, 32'h0,          4, 0, 32'h0,          6'b001111);
    vecs[6]  = mk(1, 0, 6,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 6, 0, 0, 0, 0, 32'h0,          5, 0, 32'h0,          6'b011111);
    vecs[7]  = mk(1, 0, 15, 3'b000, 12'h0,               '0,                                   3'b000, 0,  0, 0, 0, 0, 0, 0, 32'h0,          6, 0, 32'h0,          6'b111111);
    vecs[8]  = mk(0, 0, 0,  3'b101, {4'd1, 4'd0, 4'd3},  v3(32'h11, 32'h0, 32'h33),            3'b000, 1,  0, 0, 0, 0, 0, 0, 32'h0,          6, 0, 32'h0,          6'b000000);
    vecs[9]  = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 0,  0, 0, 1, 1, 0, 1, 32'h11,         6, 0, 32'h0,          6'b111010);
    vecs[10] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 0,  0, 0, 1, 1, 0, 1, 32'h11,         6, 0, 32'h0,          6'b111010);
    vecs[11] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 0,  0, 0, 1, 1, 0, 1, 32'h11,         6, 0, 32'h0,          6'b111010);
    vecs[12] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  0, 0, 1, 1, 0, 1, 32'h11,         6, 0, 32'h0,          6'b111010);
    vecs[13] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 1, 0, 0, 0, 0, 32'h0,          5, 0, 32'h0,          6'b111010);
    vecs[14] = mk(1, 0, 7,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 1, 0, 0, 0, 0, 32'h0,          5, 0, 32'h0,          6'b111010);
    vecs[15] = mk(0, 0, 0,  3'b010, {4'd0, 4'd2, 4'd0},  v3(32'h0, 32'h22, 32'h0),             3'b000, 1,  0, 0, 0, 0, 0, 0, 32'h0,          6, 0, 32'h0,          6'b000000);
    vecs[16] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  0, 0, 1, 2, 0, 2, 32'h22,         6, 0, 32'h0,          6'b111001);
    vecs[17] = mk(1, 2, 9,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 2, 1, 3, 0, 3, 32'h33,         5, 0, 32'h0,          6'b111001);
    vecs[18] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 3, 0, 0, 0, 0, 32'h0,          5, 0, 32'h0,          6'b111011);
    vecs[19] = mk(0, 0, 0,  3'b111, {4'd4, 4'd5, 4'd4},  v3(32'h4444, 32'h55, 32'h44),         3'b000, 0,  1, 3, 0, 0, 0, 0, 32'h0,          5, 0, 32'h0,          6'b000000);
    vecs[20] = mk(0, 0, 0,  3'b111, {4'd7, 4'd0, 4'd6},  v3(32'hBEEF, 32'hDEAD, 32'h66),       3'b000, 1,  1, 3, 1, 4, 0, 4, 32'h4444,       5, 0, 32'h0,          6'b000000);
    vecs[21] = mk(0, 0, 0,  3'b011, {4'd0, 4'd3, 4'd5},  v3(32'h0, 32'h333, 32'hBAD),          3'b000, 1,  1, 3, 1, 5, 0, 5, 32'h55,         4, 0, 32'h0,          6'b000000);
    vecs[22] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 3, 1, 6, 0, 6, 32'h66,         3, 0, 32'h0,          6'b000011);
    vecs[23] = mk(0, 0, 0,  3'b011, {4'd0, 4'd1, 4'd2},  v3(32'h0, 32'h77, 32'h8000_0040),     3'b001, 1,  1, 3, 0, 0, 0, 0, 32'h0,          2, 0, 32'h0,          6'b000000);
    vecs[24] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 3, 1, 1, 0, 7, 32'h77,         2, 0, 32'h0,          6'b000000);
    vecs[25] = mk(1, 0, 3,  3'b000, 12'h0,               '0,                                   3'b000, 1,  1, 3, 1, 2, 2, 0, 32'h8000_0040,  1, 0, 32'h0,          6'b000000);
    vecs[26] = mk(1, 0, 4,  3'b000, 12'h0,               '0,                                   3'b000, 1,  0, 0, 0, 0, 0, 0, 32'h0,          0, 1, 32'h8000_0040,  6'b000000);
    vecs[27] = mk(0, 0, 0,  3'b000, 12'h0,               '0,                                   3'b000, 0,  1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          6'b000000);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      if (i > 0) @(negedge clk);
      alloc_valid = vecs[i].av; alloc_op_type = vecs[i].op; alloc_rd = vecs[i].rd;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_val = vecs[i].cval;
      cdb_mispredict = vecs[i].cm; commit_ready = vecs[i].cr;
      #1;
      chk($sformatf("r%0d.alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].ar));
      chk($sformatf("r%0d.alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].at));
      chk($sformatf("r%0d.commit_valid", i), 32'(commit_valid), 32'(vecs[i].cvld));
      chk($sformatf("r%0d.commit_tag", i), 32'(commit_tag), 32'(vecs[i].ctag));
      chk($sformatf("r%0d.commit_op_type", i), 32'(commit_op_type), 32'(vecs[i].cop));
      chk($sformatf("r%0d.commit_rd", i), 32'(commit_rd), 32'(vecs[i].crd));
      chk($sformatf("r%0d.commit_val", i), commit_val, vecs[i].cvl);
      chk($sformatf("r%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("r%0d.flush", i), 32'(flush), 32'(vecs[i].fl));
      chk($sformatf("r%0d.flush_pc", i), flush_pc, vecs[i].fpc);
      // rob_busy is build-dependent while a broadcast is on the bus.
      if (vecs[i].cv == 3'b000)
        chk($sformatf("r%0d.rob_busy", i), 32'(rob_busy), 32'(vecs[i].busy));
    end

    // Bypass visibility: allocate tags 1..4, broadcast tag 4.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_inputs();
      alloc_valid = 1'b1; alloc_rd = 5'(k);
    end
    @(negedge clk);
    idle_inputs();
    cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd4}; cdb_val = v3(32'h0, 32'h0, 32'hABCD);
`ifdef ROB_CDB_BYPASS_EN
    exp_byp_busy = 1'b0; exp_byp_val = 32'hABCD;
`else
    exp_byp_busy = 1'b1; exp_byp_val = 32'h0;
`endif
    #1;
    chk("byp.busy_same_cycle", 32'(rob_busy[3]), 32'(exp_byp_busy));
    chk("byp.val_same_cycle", rob_vals[96 +: 32], exp_byp_val);
    chk("byp.commit_valid_same_cycle", 32'(commit_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("byp.busy_next_cycle", 32'(rob_busy[3]), 32'd0);
    chk("byp.val_next_cycle", rob_vals[96 +: 32], 32'hABCD);

    // Reset clears captured values; reset at a mispredict commit edge wins.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.rob_vals", 32'(rob_vals != '0), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.alloc_tag", 32'(alloc_tag), 32'd1);
    alloc_valid = 1'b1; alloc_op_type = 2'd2;
    @(negedge clk);
    idle_inputs();
    cdb_valid = 3'b100; cdb_tag = {4'd1, 4'd0, 4'd0};
    cdb_val = v3(32'h100, 32'h0, 32'h0); cdb_mispredict = 3'b100;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst2.commit_valid", 32'(commit_valid), 32'd1);
    chk("rst2.commit_op_type", 32'(commit_op_type), 32'd2);
    chk("rst2.commit_val", commit_val, 32'h100);
    commit_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    idle_inputs(); rst = 1'b0;
    #1;
    chk("rst2.flush", 32'(flush), 32'd0);
    chk("rst2.flush_pc", flush_pc, 32'h0);
    chk("rst2.alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst2.count", 32'(count), 32'd0);
    chk("rst2.commit_valid_after", 32'(commit_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
